ahb5_master_arbiter: RTL and testbench

- Shares one AHB5 slave-side address/data path between NUM_MASTERS AHB5 masters (VIP masters or RTL), granting in round-robin order.
- Sits in the multi-master bench/interconnect between the master interfaces and the slave interface.
- Grant drives the external address-phase mux; the data-phase owner ID drives the write-data mux and HRDATA/HRESP routing.
- Never breaks a fixed-length burst or a locked sequence.

---
 rtl/ahb5_master_arbiter_if.sv | 28 ++
 rtl/ahb5_master_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_ahb5_master_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb5_master_arbiter_if.sv
// Bundle of request, post-mux address-phase controls and arbitration results
// exchanged between the masters' side and the AHB5 master arbiter.
interface ahb5_master_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int MID_W       = 2
);
  logic [NUM_MASTERS-1:0] req;
  logic [1:0]             HTRANS;
  logic [2:0]             HBURST;
  logic                   HMASTLOCK;
  logic                   HREADY;
  logic [NUM_MASTERS-1:0] grant;
  logic [MID_W-1:0]       HMASTER;
  logic [MID_W-1:0]       data_master;
  logic                   data_valid;

  // Arbiter view: consumes requests and bus controls, produces ownership.
  modport slave (
    input  req, HTRANS, HBURST, HMASTLOCK, HREADY,
    output grant, HMASTER, data_master, data_valid
  );

  // Requesting side view: drives requests and controls, observes ownership.
  modport master (
    output req, HTRANS, HBURST, HMASTLOCK, HREADY,
    input  grant, HMASTER, data_master, data_valid
  );
endinterface

// File: rtl/ahb5_master_arbiter.sv
// Round-robin AHB5 master arbiter. Grants the shared address path to one
// master at a time, never breaking a fixed-length burst, an open INCR run
// whose owner still requests, or a locked sequence. Also tracks which master
// owns the current data phase for write-data / response routing.
module ahb5_master_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int MID_W       = 2
) (
  input logic                 HCLK,
  input logic                 HRESET,
  ahb5_master_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_OPEN   = 2'd0,
    ST_BURST  = 2'd1,
    ST_INCR   = 2'd2,
    ST_LOCKED = 2'd3
  } state_e;

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;
  localparam logic [2:0] HB_INCR   = 3'd1;

  // Beat count of a burst type; 0 marks the unbounded INCR.
  function automatic logic [4:0] burst_len(input logic [2:0] hb);
    logic [4:0] len;
    case (hb)
      3'd0:       len = 5'd1;
      3'd1:       len = 5'd0;
      3'd2, 3'd3: len = 5'd4;
      3'd4, 3'd5: len = 5'd8;
      default:    len = 5'd16;
    endcase
    return len;
  endfunction

  // First requesting master searching circularly after cur; cur itself is
  // reached last, and with no requests at all ownership parks on cur.
  function automatic logic [MID_W-1:0] rr_pick(input logic [NUM_MASTERS-1:0] r,
                                               input logic [MID_W-1:0] cur);
    logic [MID_W-1:0] pick;
    logic [MID_W-1:0] id;
    logic             found;
    pick  = cur;
    found = 1'b0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      id = MID_W'((int'(cur) + i) % NUM_MASTERS);
      if (!found && r[id]) begin
        pick  = id;
        found = 1'b1;
      end else begin
        pick  = pick;
      end
    end
    return pick;
  endfunction

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [MID_W-1:0]       owner_q, owner_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [MID_W-1:0]       data_master_q, data_master_d;
  logic                   data_valid_q, data_valid_d;
  state_e                 start_state_s;
  logic [3:0]             start_cnt_s;
  logic [4:0]             len_s;
  logic                   arb_s;

  // Classify the completing transfer as the start of a new sequence.
  always_comb begin
    start_state_s = ST_OPEN;
    start_cnt_s   = 4'd0;
    len_s         = burst_len(bus.HBURST);
    if (bus.HMASTLOCK && bus.HTRANS[1]) begin
      start_state_s = ST_LOCKED;
    end else if (bus.HTRANS == TR_NONSEQ && bus.HBURST == HB_INCR) begin
      start_state_s = ST_INCR;
    end else if (bus.HTRANS == TR_NONSEQ && len_s > 5'd1) begin
      start_state_s = ST_BURST;
      start_cnt_s   = len_s[3:0] - 4'd1;
    end else begin
      start_state_s = ST_OPEN;
    end
  end

  // Sequence-protection FSM and arbitration-point detection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    arb_s   = 1'b0;
    if (bus.HREADY) begin
      case (state_q)
        ST_OPEN: begin
          state_d = start_state_s;
          cnt_d   = start_cnt_s;
          arb_s   = (start_state_s == ST_OPEN);
        end
        ST_BURST: begin
          if (bus.HTRANS == TR_SEQ) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              state_d = ST_OPEN;
              arb_s   = 1'b1;
            end else begin
              state_d = ST_BURST;
            end
          end else if (bus.HTRANS == TR_IDLE) begin
            // Aborted burst (e.g. after an ERROR response).
            state_d = ST_OPEN;
            cnt_d   = 4'd0;
          end else begin
            state_d = ST_BURST;
          end
        end
        ST_INCR: begin
          if (bus.HTRANS == TR_IDLE) begin
            state_d = ST_OPEN;
            arb_s   = !bus.req[owner_q];
          end else if (bus.HTRANS == TR_NONSEQ) begin
            state_d = start_state_s;
            cnt_d   = start_cnt_s;
          end else begin
            state_d = ST_INCR;
          end
        end
        ST_LOCKED: begin
          if (!bus.HMASTLOCK && bus.HTRANS == TR_IDLE) begin
            state_d = ST_OPEN;
          end else begin
            state_d = ST_LOCKED;
          end
        end
        default: begin
          state_d = ST_OPEN;
          cnt_d   = 4'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Ownership update and data-phase tracking; both frozen during wait states.
  always_comb begin
    owner_d       = owner_q;
    data_master_d = data_master_q;
    data_valid_d  = data_valid_q;
    if (arb_s) begin
      owner_d = rr_pick(bus.req, owner_q);
    end else begin
      owner_d = owner_q;
    end
    if (bus.HREADY) begin
      data_master_d = owner_q;
      data_valid_d  = bus.HTRANS[1];
    end else begin
      data_valid_d  = data_valid_q;
    end
    grant_d = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << owner_d;
  end

  // State registers; reset parks ownership on master 0.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q       <= ST_OPEN;
      cnt_q         <= 4'd0;
      owner_q       <= '0;
      grant_q       <= {{(NUM_MASTERS-1){1'b0}}, 1'b1};
      data_master_q <= '0;
      data_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      owner_q       <= owner_d;
      grant_q       <= grant_d;
      data_master_q <= data_master_d;
      data_valid_q  <= data_valid_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.HMASTER     = owner_q;
  assign bus.data_master = data_master_q;
  assign bus.data_valid  = data_valid_q;

endmodule

// File: tb/tb_ahb5_master_arbiter.sv
// Self-checking bench for ahb5_master_arbiter: directed scenarios with fixed
// expectations followed by random traffic against a behavioural model.
module tb_ahb5_master_arbiter;

  logic HCLK = 1'b0;
  logic HRESET;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model state: owner, data-phase owner/valid, lock held, beats left
  // in a fixed burst (-1 means an open-ended INCR run).
  int   m_owner, m_dm, m_left;
  logic m_dv, m_lock;

  ahb5_master_arbiter_if #(.NUM_MASTERS(4), .MID_W(2)) bus ();

  ahb5_master_arbiter #(.NUM_MASTERS(4), .MID_W(2)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus.slave)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  task automatic drive(input logic [3:0] r, input logic [1:0] t, input logic [2:0] b,
                       input logic l, input logic rd);
    bus.req = r; bus.HTRANS = t; bus.HBURST = b; bus.HMASTLOCK = l; bus.HREADY = rd;
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    drive(4'b0000, 2'd0, 3'd0, 1'b0, 1'b1);
    step(); step();
    HRESET = 1'b0;
    m_owner = 0; m_dm = 0; m_dv = 1'b0; m_lock = 1'b0; m_left = 0;
  endtask

  task automatic model_start();
    int hb;
    hb = int'(bus.HBURST);
    m_left = 0;
    if (bus.HMASTLOCK && bus.HTRANS[1]) m_lock = 1'b1;
    else if (bus.HTRANS == 2'd2) begin
      if (hb == 1) m_left = -1;
      else if (hb == 0) m_left = 0;
      else m_left = (4 << ((hb - 2) / 2)) - 1;
    end
  endtask

  task automatic model_step();
    logic arb;
    logic found;
    int   cand;
    arb = 1'b0;
    if (bus.HREADY) begin
      if (m_lock) begin
        if (!bus.HMASTLOCK && bus.HTRANS == 2'd0) m_lock = 1'b0;
      end else if (m_left > 0) begin
        if (bus.HTRANS == 2'd3) begin
          m_left = m_left - 1;
          arb = (m_left == 0);
        end else if (bus.HTRANS == 2'd0) m_left = 0;
      end else if (m_left < 0) begin
        if (bus.HTRANS == 2'd0) begin
          m_left = 0;
          arb = !bus.req[m_owner];
        end else if (bus.HTRANS == 2'd2) model_start();
      end else begin
        model_start();
        arb = !m_lock && (m_left == 0);
      end
      m_dm = m_owner;
      m_dv = bus.HTRANS[1];
      if (arb) begin
        found = 1'b0;
        cand  = m_owner;
        for (int i = 1; i <= 4; i++) begin
          if (!found && bus.req[(m_owner + i) % 4]) begin
            cand = (m_owner + i) % 4;
            found = 1'b1;
          end
        end
        m_owner = cand;
      end
    end
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    drive(4'b1111, 2'd2, 3'd0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if (bus.grant !== 4'b0001 || bus.HMASTER !== 2'd0 || bus.data_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL reset: got grant=%b HMASTER=%0d dv=%b want 0001/0/0",
                 bus.grant, bus.HMASTER, bus.data_valid);
      end
    end
    HRESET = 1'b0;
  endtask

  task automatic test_round_robin();
    do_reset();
    drive(4'b1111, 2'd2, 3'd0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++;
      if (bus.HMASTER !== 2'((k + 1) % 4) || bus.grant !== (4'b0001 << ((k + 1) % 4))
          || bus.data_master !== 2'(k) || bus.data_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL round_robin[%0d]: got HMASTER=%0d grant=%b dm=%0d dv=%b want %0d/dm %0d/1",
                 k, bus.HMASTER, bus.grant, bus.data_master, bus.data_valid, (k + 1) % 4, k);
      end
    end
  endtask

  task automatic test_burst();
    logic [3:0] want;
    do_reset();
    drive(4'b0110, 2'd0, 3'd0, 1'b0, 1'b1);
    step();
    drive(4'b0110, 2'd2, 3'd3, 1'b0, 1'b1);  // beat 1 NONSEQ INCR4
    step();
    // beat 2 with two wait states, then beats 2..4 complete
    for (int k = 0; k < 5; k++) begin
      drive(4'b0110, 2'd3, 3'd3, 1'b0, (k >= 2));
      step();
      want = (k == 4) ? 4'b0100 : 4'b0010;
      n_cmp++;
      if (bus.grant !== want) begin
        n_bad++;
        $display("FAIL burst_grant[%0d]: got %b want %b", k, bus.grant, want);
      end
    end
  endtask

  task automatic test_lock();
    logic [3:0] want;
    do_reset();
    drive(4'b0100, 2'd0, 3'd0, 1'b0, 1'b1);
    step();
    for (int k = 0; k < 5; k++) begin
      if (k < 3) drive(4'b1111, 2'd2, 3'd0, 1'b1, 1'b1);
      else drive(4'b1111, 2'd0, 3'd0, 1'b0, 1'b1);
      step();
      want = (k == 4) ? 4'b1000 : 4'b0100;
      n_cmp++;
      if (bus.grant !== want) begin
        n_bad++;
        $display("FAIL lock_grant[%0d]: got %b want %b", k, bus.grant, want);
      end
    end
  endtask

  task automatic test_data_phase();
    do_reset();
    drive(4'b1001, 2'd2, 3'd0, 1'b0, 1'b1);
    step();
    for (int k = 0; k < 4; k++) begin
      drive(4'b1001, 2'd2, 3'd0, 1'b0, 1'b0);
      if (k > 0) step();
      n_cmp++;
      if (bus.HMASTER !== 2'd3 || bus.data_master !== 2'd0 || bus.data_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL data_phase_wait[%0d]: got HMASTER=%0d dm=%0d dv=%b want 3/0/1",
                 k, bus.HMASTER, bus.data_master, bus.data_valid);
      end
    end
    drive(4'b1000, 2'd2, 3'd0, 1'b0, 1'b1);
    step();
    n_cmp++;
    if (bus.data_master !== 2'd3) begin
      n_bad++;
      $display("FAIL data_phase_release: got dm=%0d want 3", bus.data_master);
    end
  endtask

  task automatic test_park_and_reset();
    do_reset();
    drive(4'b1000, 2'd0, 3'd0, 1'b0, 1'b1);
    step();
    drive(4'b0000, 2'd0, 3'd0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if (bus.HMASTER !== 2'd3 || bus.grant !== 4'b1000) begin
        n_bad++;
        $display("FAIL park[%0d]: got HMASTER=%0d grant=%b want 3/1000", k, bus.HMASTER, bus.grant);
      end
    end
    drive(4'b0010, 2'd0, 3'd0, 1'b0, 1'b1);
    step();
    drive(4'b0010, 2'd2, 3'd5, 1'b0, 1'b1);  // INCR8 beat 1
    step();
    for (int k = 0; k < 3; k++) begin
      drive(4'b0010, 2'd3, 3'd5, 1'b0, 1'b1);
      step();
    end
    drive(4'b0010, 2'd3, 3'd5, 1'b0, 1'b1);  // beat 5 on the bus
    n_cmp++;
    if (bus.grant !== 4'b0010 || bus.data_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_burst_owner: got grant=%b dv=%b want 0010/1", bus.grant, bus.data_valid);
    end
    #2 HRESET = 1'b1;
    #1;
    n_cmp++;
    if (bus.grant !== 4'b0001 || bus.HMASTER !== 2'd0 || bus.data_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: got grant=%b HMASTER=%0d dv=%b want 0001/0/0",
               bus.grant, bus.HMASTER, bus.data_valid);
    end
    step();
    HRESET = 1'b0;
    // In OPEN a completed SINGLE arbitrates at once; a leftover burst would not.
    drive(4'b0010, 2'd2, 3'd0, 1'b0, 1'b1);
    step();
    n_cmp++;
    if (bus.HMASTER !== 2'd1 || bus.grant !== 4'b0010) begin
      n_bad++;
      $display("FAIL post_reset_open: got HMASTER=%0d grant=%b want 1/0010", bus.HMASTER, bus.grant);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      drive(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
      model_step();
      step();
      n_cmp++;
      if (bus.HMASTER !== 2'(m_owner) || bus.grant !== (4'b0001 << m_owner)
          || bus.data_master !== 2'(m_dm) || bus.data_valid !== m_dv) begin
        n_bad++;
        $display("FAIL random[%0d]: got HMASTER=%0d grant=%b dm=%0d dv=%b want %0d/%b/%0d/%b",
                 k, bus.HMASTER, bus.grant, bus.data_master, bus.data_valid,
                 m_owner, 4'b0001 << m_owner, m_dm, m_dv);
      end
    end
  endtask

  initial begin
    HRESET = 1'b1;
    drive(4'b0000, 2'd0, 3'd0, 1'b0, 1'b1);
    test_reset();
    test_round_robin();
    test_burst();
    test_lock();
    test_data_phase();
    test_park_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
